// File: rtl/packet_switch_pkg.sv
// Shared constants for the packet_switch lookup path.
// Holds the TCAM key/result widths, the channel limit of the multi-channel
// lookup interface and the bit positions inside its err_sticky vector.
package packet_switch_pkg;

  localparam int unsigned tuple_map_width   = 32;
  localparam int unsigned TCAM_RESULT_WIDTH = 16;

  localparam int unsigned LKUP_MAX_CH = 16;

  // err_sticky bit positions
  localparam int unsigned ERR_BAD_TID = 0;
  localparam int unsigned ERR_RSP_OVF = 1;
  localparam int unsigned ERR_RSP_UDF = 2;
  localparam int unsigned ERR_WIDTH   = 3;

endpackage

// File: rtl/lkup_rr_arb.sv
// Round-robin arbiter over NUM_CH request lines.
// Ports: clk/rst (sync, active-high); req request vector; advance strobe
// (grant accepted); grant one-hot, grant_idx index, grant_vld any request.
// Grant outputs are combinational from req and the rotating pointer; the
// pointer moves past the winner only when advance is seen with a grant.
module lkup_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_vld
);

  logic [IW-1:0] ptr_r;
  int            cand_s;

  // Scan from the lowest priority rank to the highest so the last hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_s    = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand_s    = (int'(ptr_r) + off >= NUM_CH) ? int'(ptr_r) + off - NUM_CH
                                                : int'(ptr_r) + off;
      grant_idx = req[cand_s[IW-1:0]] ? cand_s[IW-1:0] : grant_idx;
      grant_vld = grant_vld | req[cand_s[IW-1:0]];
    end
  end

  assign grant = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

  // Rotating priority pointer, advanced past the accepted winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && grant_vld) begin
      ptr_r <= (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/packet_switch_ipbb_sdc_fifo_inff.sv
// Single-clock show-ahead FIFO with a registered output word.
// Ports: clk/rst (sync, active-high); wr/wr_data push; rd pops the head;
// rd_data/empty describe the registered head; overflow/underflow are
// one-cycle pulses on a push into a full store or a pop while empty.
// A pushed word reaches the head two edges after the push is presented.
module packet_switch_ipbb_sdc_fifo_inff
  import packet_switch_pkg::*;
#(
  parameter int DWD       = 17,
  parameter int NUM_WORDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr,
  input  logic [DWD-1:0] wr_data,
  input  logic           rd,
  output logic [DWD-1:0] rd_data,
  output logic           empty,
  output logic           overflow,
  output logic           underflow
);

  localparam int AW = $clog2(NUM_WORDS);

  logic [DWD-1:0] mem_r [NUM_WORDS];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    cnt_r;
  logic           out_vld_r;
  logic [DWD-1:0] out_data_r;
  logic           load_s;
  logic           wr_ok_s;

  // Refill the head register whenever it is free or being popped.
  always_comb begin
    load_s  = (cnt_r != '0) && (!out_vld_r || rd);
    wr_ok_s = wr && ((cnt_r != (AW+1)'(NUM_WORDS)) || load_s);
  end

  // Storage array; no reset needed, validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, head register and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
      out_vld_r  <= 1'b0;
      out_data_r <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      cnt_r <= cnt_r + {{AW{1'b0}}, wr_ok_s} - {{AW{1'b0}}, load_s};
      if (load_s) begin
        out_data_r <= mem_r[rd_ptr_r];
        out_vld_r  <= 1'b1;
        rd_ptr_r   <= rd_ptr_r + AW'(1);
      end else if (rd) begin
        out_vld_r <= 1'b0;
      end
      overflow  <= wr && !wr_ok_s;
      underflow <= rd && !out_vld_r;
    end
  end

  assign rd_data = out_data_r;
  assign empty   = !out_vld_r;

endmodule

// File: rtl/lkup_tcam_mc_intf.sv
// Multi-channel TCAM lookup interface.
// Round-robin arbitrates NUM_CH request queues onto one TCAM key port
// (tagged with the channel id) and steers tagged responses into per-channel
// response FIFOs. Per-channel credits (outstanding + queued) cap each channel
// at RSP_FIFO_DEPTH so responses never need back-pressure.
// Ports:
//   clk, rst                       clock, sync active-high reset
//   ch_req_empty/key/rd            per-channel request queues (rd = pop)
//   tcam_req_*                     key request to the TCAM
//   tcam_rsp_*                     tagged response from the TCAM
//   rsp_fifo_empty/rd              per-channel response FIFO status/pop
//   tcam_rsp_found/result          per-channel response FIFO head
//   err_sticky                     [0] bad tid, [1] overflow, [2] underflow
module lkup_tcam_mc_intf
  import packet_switch_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CHTID_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int KEY_WIDTH      = int'(tuple_map_width),
  parameter int RESULT_WIDTH   = int'(TCAM_RESULT_WIDTH),
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_req_empty,
  input  logic [NUM_CH*KEY_WIDTH-1:0]    ch_req_key,
  output logic [NUM_CH-1:0]              ch_req_rd,
  output logic                           tcam_req_tvalid,
  input  logic                           tcam_req_tready,
  output logic [CHTID_WIDTH-1:0]         tcam_req_tid,
  output logic [KEY_WIDTH-1:0]           tcam_req_tuser_key,
  input  logic                           tcam_rsp_tvalid,
  input  logic [CHTID_WIDTH-1:0]         tcam_rsp_tid,
  input  logic                           tcam_rsp_tuser_found,
  input  logic [RESULT_WIDTH-1:0]        tcam_rsp_tuser_result,
  output logic                           tcam_rsp_tready,
  output logic [NUM_CH-1:0]              rsp_fifo_empty,
  input  logic [NUM_CH-1:0]              rsp_fifo_rd,
  output logic [NUM_CH-1:0]              tcam_rsp_found,
  output logic [NUM_CH*RESULT_WIDTH-1:0] tcam_rsp_result,
  output logic [2:0]                     err_sticky
);

  localparam int CW  = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam int DWD = 1 + RESULT_WIDTH;

  logic                    rst_q_r;
  logic                    rsp_tready_r;
  logic                    run_s;
  logic [NUM_CH-1:0]       elig_s;
  logic [NUM_CH-1:0]       grant_oh_s;
  logic [CHTID_WIDTH-1:0]  grant_idx_s;
  logic                    grant_vld_s;
  logic                    fire_s;
  logic [KEY_WIDTH-1:0]    key_s;
  logic [CW-1:0]           cred_r [NUM_CH];
  logic [NUM_CH-1:0]       cred_inc_s;
  logic [NUM_CH-1:0]       cred_dec_s;
  logic                    rsp_acc_s;
  logic                    tid_ok_s;
  logic                    rsp_vld_r;
  logic [CHTID_WIDTH-1:0]  rsp_tid_r;
  logic                    rsp_found_r;
  logic [RESULT_WIDTH-1:0] rsp_result_r;
  logic [NUM_CH-1:0]       fifo_wr_s;
  logic [NUM_CH-1:0]       fifo_ovf_s;
  logic [NUM_CH-1:0]       fifo_udf_s;
  logic [DWD-1:0]          fifo_dout_s [NUM_CH];
  logic [2:0]              err_r;

  // Two-stage reset release: tready (and arbitration) stays off for the
  // reset cycle and the one after, giving the TCAM time to come out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q_r      <= 1'b1;
      rsp_tready_r <= 1'b0;
    end else begin
      rst_q_r      <= 1'b0;
      rsp_tready_r <= !rst_q_r;
    end
  end

  assign run_s = rsp_tready_r && !rst;

  // Eligibility, key selection and credit strobes.
  always_comb begin
    key_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig_s[c]     = run_s && !ch_req_empty[c] && (cred_r[c] < CW'(RSP_FIFO_DEPTH));
      key_s         = key_s | ({KEY_WIDTH{grant_oh_s[c]}} & ch_req_key[c*KEY_WIDTH +: KEY_WIDTH]);
      cred_inc_s[c] = fire_s && grant_oh_s[c];
      cred_dec_s[c] = rsp_fifo_rd[c] && !rsp_fifo_empty[c];
    end
  end

  lkup_rr_arb #(
    .NUM_CH (NUM_CH),
    .IW     (CHTID_WIDTH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig_s),
    .advance   (fire_s),
    .grant     (grant_oh_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  assign fire_s             = grant_vld_s && tcam_req_tready;
  assign tcam_req_tvalid    = grant_vld_s;
  assign tcam_req_tid       = grant_idx_s;
  assign tcam_req_tuser_key = key_s;
  assign ch_req_rd          = grant_oh_s & {NUM_CH{fire_s}};
  assign tcam_rsp_tready    = rsp_tready_r;

  // Per-channel credit counters: +1 on grant, -1 on a real pop.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        cred_r[c] <= '0;
      end else begin
        case ({cred_inc_s[c], cred_dec_s[c]})
          2'b10:   cred_r[c] <= cred_r[c] + CW'(1);
          2'b01:   cred_r[c] <= cred_r[c] - CW'(1);
          default: cred_r[c] <= cred_r[c];
        endcase
      end
    end
  end

  assign rsp_acc_s = tcam_rsp_tvalid && rsp_tready_r;
  assign tid_ok_s  = ({1'b0, tcam_rsp_tid} < (CHTID_WIDTH+1)'(NUM_CH));

  // One register stage on the response path; out-of-range tags are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_r    <= 1'b0;
      rsp_tid_r    <= '0;
      rsp_found_r  <= 1'b0;
      rsp_result_r <= '0;
    end else begin
      rsp_vld_r    <= rsp_acc_s && tid_ok_s;
      rsp_tid_r    <= tcam_rsp_tid;
      rsp_found_r  <= tcam_rsp_tuser_found;
      rsp_result_r <= tcam_rsp_tuser_result;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign fifo_wr_s[c] = rsp_vld_r && (rsp_tid_r == CHTID_WIDTH'(c));

    packet_switch_ipbb_sdc_fifo_inff #(
      .DWD       (DWD),
      .NUM_WORDS (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr        (fifo_wr_s[c]),
      .wr_data   ({rsp_found_r, rsp_result_r}),
      .rd        (rsp_fifo_rd[c]),
      .rd_data   (fifo_dout_s[c]),
      .empty     (rsp_fifo_empty[c]),
      .overflow  (fifo_ovf_s[c]),
      .underflow (fifo_udf_s[c])
    );

    assign tcam_rsp_found[c]                                  = fifo_dout_s[c][DWD-1];
    assign tcam_rsp_result[c*RESULT_WIDTH +: RESULT_WIDTH]    = fifo_dout_s[c][RESULT_WIDTH-1:0];
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= '0;
    end else begin
      err_r[ERR_BAD_TID] <= err_r[ERR_BAD_TID] | (rsp_acc_s && !tid_ok_s);
      err_r[ERR_RSP_OVF] <= err_r[ERR_RSP_OVF] | (|fifo_ovf_s);
      err_r[ERR_RSP_UDF] <= err_r[ERR_RSP_UDF] | (|fifo_udf_s);
    end
  end

  assign err_sticky = err_r;

endmodule
